gmux8way16_rr: RTL

- Gathering counterpart of the 8-way 16-bit demultiplexer: merges eight 16-bit source channels into one output stream.
- Uses round-robin arbitration and per-channel valid/ready handshakes.
- The output stage is a single registered entry and carries the source index with the data, so a downstream demux can route by it.
- Sits between the per-channel producers (PC/memory side) and a shared consumer.

---
 rtl/gmux_pkg.sv | 12 +
 rtl/rr_arbiter8.sv | 43 ++++
 rtl/gmux8way16_rr.sv | 117 +++++++++++
 3 files changed

// File: rtl/gmux_pkg.sv
// Shared types and sizes for the 8-way 16-bit round-robin gather mux.
//   WIDTH - data width per channel and on the output
//   NCH   - number of source channels
//   SEL_W - width of a channel index
package gmux_pkg;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter over eight requesters.
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - request vector, bit i = requester i
//   advance    - grant was taken this cycle; move priority past it
//   grant_idx  - index of the first requester at or after the priority pointer
//   grant_vld  - at least one request present
module rr_arbiter8
  import gmux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       advance,
  output logic [2:0] grant_idx,
  output logic       grant_vld
);

  sel_t ptr_q, ptr_d;

  // Scan from ptr upward; the 3-bit add wraps 7 -> 0.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_vld && req[ptr_q + sel_t'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_q + sel_t'(i);
      end
    end
  end

  // Priority only rotates on an accepted grant; idle cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld) ptr_d = grant_idx + sel_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gmux8way16_rr.sv
// Gathers eight 16-bit channels into one registered output stream with
// round-robin arbitration. The output word carries its source index.
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - per-channel data present
//   d0..d7      - per-channel data, stable until accepted
//   in_ready    - one-hot accept strobe for the granted channel (or zero)
//   out_valid   - output register holds a word
//   out_data    - held word
//   out_sel     - channel that supplied out_data
//   out_ready   - consumer takes out_data this cycle
//   xfer_count  - words delivered downstream, wraps at 16 bits
module gmux8way16_rr
  import gmux_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_valid,
  input  logic [15:0] d0,
  input  logic [15:0] d1,
  input  logic [15:0] d2,
  input  logic [15:0] d3,
  input  logic [15:0] d4,
  input  logic [15:0] d5,
  input  logic [15:0] d6,
  input  logic [15:0] d7,
  output logic [7:0]  in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [2:0]  out_sel,
  input  logic        out_ready,
  output logic [15:0] xfer_count
);

  logic        out_valid_q, out_valid_d;
  word_t       out_data_q,  out_data_d;
  sel_t        out_sel_q,   out_sel_d;
  logic [15:0] xfer_count_q, xfer_count_d;

  sel_t  grant_idx;
  logic  grant_vld;
  logic  space;
  logic  accept;
  logic  drain;
  word_t d_grant;

  rr_arbiter8 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (accept),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // rst_n gating keeps in_ready low while reset is held, even though the
  // cleared output register would otherwise report space.
  assign space  = !out_valid_q || out_ready;
  assign accept = grant_vld && space && rst_n;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    d_grant = '0;
    case (grant_idx)
      3'd0: d_grant = d0;
      3'd1: d_grant = d1;
      3'd2: d_grant = d2;
      3'd3: d_grant = d3;
      3'd4: d_grant = d4;
      3'd5: d_grant = d5;
      3'd6: d_grant = d6;
      3'd7: d_grant = d7;
      default: d_grant = '0;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    xfer_count_d = xfer_count_q;
    if (drain) begin
      out_valid_d  = 1'b0;
      xfer_count_d = xfer_count_q + 16'd1;
    end
    // A load in the same cycle as a drain replaces the outgoing word.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = d_grant;
      out_sel_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sel    = out_sel_q;
  assign xfer_count = xfer_count_q;

endmodule
